// File: rtl/stopwatch_pkg.sv
// Shared types, state encoding and BCD helpers for the stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StSplit = 2'b10,
        StStop  = 2'b11
    } sw_state_e;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [31:0] time_bcd_t;

    localparam logic [7:0] Lim59 = 8'h59;
    localparam logic [7:0] Lim99 = 8'h99;

    // Increment a two-digit BCD value, wrapping to 00 after lim; bit 8 is the carry.
    function automatic logic [8:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lim);
        bcd_digit_t hi;
        bcd_digit_t lo;
        hi = v[7:4];
        lo = v[3:0];
        if (v == lim) begin
            return 9'h100;
        end else if (lo == 4'd9) begin
            return {1'b0, hi + 4'd1, 4'd0};
        end else begin
            return {1'b0, hi, lo + 4'd1};
        end
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_time_counter.sv
// Tick prescaler feeding a cent/sec/min/hr BCD cascade with a wrap pulse at the top.
module bcd_time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICKS_PER_CENT = 10,
    parameter int unsigned HR_MAX         = 99
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        tick_i,
    input  logic        zero_i,
    output logic [31:0] time_o,
    output logic        wrap_o
);

    localparam int unsigned PW = (TICKS_PER_CENT > 1) ? $clog2(TICKS_PER_CENT) : 1;
    localparam logic [PW-1:0] PresMax = PW'(TICKS_PER_CENT - 1);
    localparam logic [7:0] HrMaxBcd = {4'(HR_MAX / 10), 4'(HR_MAX % 10)};

    logic [PW-1:0] pres_q, pres_d;
    time_bcd_t     time_q, time_d;
    logic          cent_step;
    logic [8:0]    cent_n, sec_n, min_n, hr_n;

    always_comb begin
        cent_step = enable_i && tick_i && (pres_q == PresMax);
        pres_d    = pres_q;
        if (enable_i && tick_i) begin
            pres_d = cent_step ? '0 : pres_q + 1'b1;
        end
        cent_n = bcd2_inc(time_q[7:0], Lim99);
        sec_n  = bcd2_inc(time_q[15:8], Lim59);
        min_n  = bcd2_inc(time_q[23:16], Lim59);
        hr_n   = bcd2_inc(time_q[31:24], HrMaxBcd);
        time_d = time_q;
        wrap_o = 1'b0;
        if (cent_step) begin
            time_d[7:0] = cent_n[7:0];
            if (cent_n[8]) begin
                time_d[15:8] = sec_n[7:0];
                if (sec_n[8]) begin
                    time_d[23:16] = min_n[7:0];
                    if (min_n[8]) begin
                        time_d[31:24] = hr_n[7:0];
                        wrap_o        = hr_n[8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pres_q <= '0;
            time_q <= '0;
        end else if (zero_i) begin
            pres_q <= '0;
            time_q <= '0;
        end else begin
            pres_q <= pres_d;
            if (cent_step) begin
                time_q <= time_d;
            end
        end
    end

    assign time_o = time_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch top: button edge detection, control FSM, circular lap buffer and display mux.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned LAP_DEPTH      = 4,
    parameter int unsigned TICKS_PER_CENT = 10,
    parameter int unsigned HR_MAX         = 99
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        tick_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        split_i,
    input  logic                        clear_i,
    input  logic                        recall_i,
    output logic [31:0]                 disp_bcd_o,
    output logic [1:0]                  state_o,
    output logic [$clog2(LAP_DEPTH):0]  lap_cnt_o,
    output logic [$clog2(LAP_DEPTH):0]  recall_idx_o,
    output logic                        ovf_o
);

    localparam int unsigned PtrW = $clog2(LAP_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] LapFull = CntW'(LAP_DEPTH);

    // Bit order: 0 stop, 1 split, 2 start, 3 clear, 4 recall (priority high to low).
    logic [4:0]      btn, sync1_q, sync2_q, prev_q, evt;
    logic [1:0]      arm_q;
    logic            ev_stop, ev_split, ev_start, ev_clear, ev_recall;
    sw_state_e       state_q, state_d;
    logic            push, clr, rec_step, rec_zero;
    time_bcd_t       live_time, frozen_q, disp_q, disp_d;
    time_bcd_t       lap_mem [LAP_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, oldest, rd_ptr;
    logic [CntW-1:0] lap_cnt_q, recall_idx_q;
    logic            ovf_q, wrap;

    assign btn = {recall_i, clear_i, start_i, split_i, stop_i};

    // Edges are masked until the history flops hold samples taken after reset release,
    // so a button held across reset is not seen as a new press.
    assign evt = (arm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;

    assign ev_stop   = evt[0];
    assign ev_split  = evt[1] & ~evt[0];
    assign ev_start  = evt[2] & ~|evt[1:0];
    assign ev_clear  = evt[3] & ~|evt[2:0];
    assign ev_recall = evt[4] & ~|evt[3:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        clr      = 1'b0;
        rec_step = 1'b0;
        rec_zero = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_start) state_d = StRun;
            end
            StRun: begin
                if (ev_stop) begin
                    state_d = StStop;
                end else if (ev_split) begin
                    state_d = StSplit;
                    push    = 1'b1;
                end
            end
            StSplit: begin
                if (ev_stop) state_d = StStop;
                else if (ev_split) state_d = StRun;
            end
            StStop: begin
                if (ev_start) begin
                    state_d  = StRun;
                    rec_zero = 1'b1;
                end else if (ev_clear) begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end else if (ev_recall && lap_cnt_q != '0) begin
                    rec_step = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    bcd_time_counter #(
        .TICKS_PER_CENT (TICKS_PER_CENT),
        .HR_MAX         (HR_MAX)
    ) u_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i ((state_q == StRun) || (state_q == StSplit)),
        .tick_i   (tick_i),
        .zero_i   (clr),
        .time_o   (live_time),
        .wrap_o   (wrap)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            lap_mem[wr_ptr_q] <= live_time;
        end
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign oldest = (lap_cnt_q == LapFull) ? wr_ptr_q : '0;
    assign rd_ptr = oldest + PtrW'(recall_idx_q - 1'b1);

    always_comb begin
        disp_d = live_time;
        if (state_q == StSplit) begin
            disp_d = frozen_q;
        end else if (state_q == StStop && recall_idx_q != '0) begin
            disp_d = lap_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            disp_q       <= '0;
            frozen_q     <= '0;
            wr_ptr_q     <= '0;
            lap_cnt_q    <= '0;
            recall_idx_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            if (clr) begin
                wr_ptr_q     <= '0;
                lap_cnt_q    <= '0;
                recall_idx_q <= '0;
                ovf_q        <= 1'b0;
            end else begin
                if (push) begin
                    frozen_q <= live_time;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (lap_cnt_q != LapFull) begin
                        lap_cnt_q <= lap_cnt_q + 1'b1;
                    end
                end
                if (rec_zero) begin
                    recall_idx_q <= '0;
                end else if (rec_step) begin
                    recall_idx_q <= (recall_idx_q == lap_cnt_q) ? '0 : recall_idx_q + 1'b1;
                end
                if (wrap) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign disp_bcd_o   = disp_q;
    assign state_o      = state_q;
    assign lap_cnt_o    = lap_cnt_q;
    assign recall_idx_o = recall_idx_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_stopwatch_core;

    localparam logic [4:0] BStop   = 5'b00001;
    localparam logic [4:0] BSplit  = 5'b00010;
    localparam logic [4:0] BStart  = 5'b00100;
    localparam logic [4:0] BClear  = 5'b01000;
    localparam logic [4:0] BRecall = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n, tick, start, stop, split, clear, recall;
    logic [31:0] disp;
    logic [1:0]  st;
    logic [2:0]  lc, ri;
    logic        ovf;

    typedef struct packed {
        logic [31:0] disp;
        logic [1:0]  st;
        logic [2:0]  lc;
        logic [2:0]  ri;
        logic        ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur;
    string cur_name;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    stopwatch_core #(
        .LAP_DEPTH      (4),
        .TICKS_PER_CENT (1),
        .HR_MAX         (99)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_i       (tick),
        .start_i      (start),
        .stop_i       (stop),
        .split_i      (split),
        .clear_i      (clear),
        .recall_i     (recall),
        .disp_bcd_o   (disp),
        .state_o      (st),
        .lap_cnt_o    (lc),
        .recall_idx_o (ri),
        .ovf_o        (ovf)
    );

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            checks++;
            if ({disp, st, lc, ri, ovf} !== cur) begin
                errors++;
                $display("FAIL %s: got disp=%h state=%0d lap_cnt=%0d recall_idx=%0d ovf=%0b, want disp=%h state=%0d lap_cnt=%0d recall_idx=%0d ovf=%0b",
                         cur_name, disp, st, lc, ri, ovf,
                         cur.disp, cur.st, cur.lc, cur.ri, cur.ovf);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [4:0] m);
        {recall, clear, start, split, stop} = m;
    endtask

    task automatic press(input logic [4:0] m);
        set_btn(m);
        cyc(3);
        set_btn('0);
        cyc(2);
    endtask

    // Same as press, but with a tick on the edge where the state changes.
    task automatic press_tick(input logic [4:0] m);
        set_btn(m);
        cyc(2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        set_btn('0);
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
        end
        tick = 1'b0;
    endtask

    task automatic expect_now(input string n, input logic [31:0] d, input logic [1:0] s,
                              input logic [2:0] l, input logic [2:0] r, input logic o);
        exp_t e;
        e.disp = d;
        e.st   = s;
        e.lc   = l;
        e.ri   = r;
        e.ovf  = o;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [31:0] d, input logic [1:0] s,
                              input logic [2:0] l, input logic [2:0] r, input logic o);
        cyc(1);
        expect_now(n, d, s, l, r, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        set_btn('0);
        cyc(2);
        expect_now("reset", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);
        rst_n = 1'b1;
        cyc(5);

        // Run, stop, hold
        press(BStart);
        expect_out("start", 32'h0, 2'd1, 3'd0, 3'd0, 1'b0);
        ticks(150);
        expect_out("run150", 32'h00000150, 2'd1, 3'd0, 3'd0, 1'b0);
        press(BStop);
        expect_out("stop150", 32'h00000150, 2'd3, 3'd0, 3'd0, 1'b0);
        ticks(10);
        expect_out("held150", 32'h00000150, 2'd3, 3'd0, 3'd0, 1'b0);
        press(BClear);
        expect_out("clear1", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);

        // Split freezes the display while counting continues
        press(BStart);
        ticks(25);
        press(BSplit);
        expect_out("split_frz", 32'h00000025, 2'd2, 3'd1, 3'd0, 1'b0);
        ticks(30);
        expect_out("frz_hold", 32'h00000025, 2'd2, 3'd1, 3'd0, 1'b0);
        press(BSplit);
        expect_out("split_live", 32'h00000055, 2'd1, 3'd1, 3'd0, 1'b0);
        press(BStop);
        press(BClear);
        expect_out("clear2", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);

        // Five laps into a four-deep buffer, then recall them
        press(BStart);
        for (int k = 1; k <= 5; k++) begin
            ticks(1);
            press(BSplit);
            press(BSplit);
        end
        expect_out("laps5", 32'h00000005, 2'd1, 3'd4, 3'd0, 1'b0);
        press(BStop);
        expect_out("stop_laps", 32'h00000005, 2'd3, 3'd4, 3'd0, 1'b0);
        for (int r = 1; r <= 5; r++) begin
            press(BRecall);
            expect_out($sformatf("recall%0d", r), (r == 5) ? 32'h5 : 32'(r + 1), 2'd3, 3'd4,
                       (r == 5) ? 3'd0 : 3'(r), 1'b0);
        end
        press(BRecall);
        expect_out("recall_again", 32'h00000002, 2'd3, 3'd4, 3'd1, 1'b0);
        press(BStart);
        expect_out("start_zero_idx", 32'h00000005, 2'd1, 3'd4, 3'd0, 1'b0);
        press(BStop);
        press(BClear);
        expect_out("clear3", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);

        // Cascade carry and overflow wrap
        press(BStart);
        dut.u_counter.time_q = 32'h00595999;
        ticks(1);
        expect_out("carry_hr", 32'h01000000, 2'd1, 3'd0, 3'd0, 1'b0);
        dut.u_counter.time_q = 32'h99595999;
        ticks(1);
        expect_out("ovf_wrap", 32'h0, 2'd1, 3'd0, 3'd0, 1'b1);
        ticks(3);
        expect_out("ovf_sticky", 32'h00000003, 2'd1, 3'd0, 3'd0, 1'b1);
        press(BStop);
        press(BClear);
        expect_out("ovf_clear", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);

        // Stop and split together; tick on the transition edge is counted
        press(BStart);
        ticks(4);
        press_tick(BStop | BSplit);
        expect_out("stop_split", 32'h00000005, 2'd3, 3'd0, 3'd0, 1'b0);
        ticks(2);
        expect_out("stop_held", 32'h00000005, 2'd3, 3'd0, 3'd0, 1'b0);
        press(BClear);

        // Async reset in SPLIT, start held across release
        press(BStart);
        ticks(1);
        press(BSplit);
        press(BSplit);
        ticks(1);
        press(BSplit);
        press(BSplit);
        ticks(1);
        press(BSplit);
        expect_out("split_lap3", 32'h00000003, 2'd2, 3'd3, 3'd0, 1'b0);
        cyc(1);
        rst_n = 1'b0;
        start = 1'b1;
        expect_now("async_rst", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        expect_out("held_start", 32'h0, 2'd0, 3'd0, 3'd0, 1'b0);
        start = 1'b0;
        cyc(2);
        press(BStart);
        expect_out("fresh_start", 32'h0, 2'd1, 3'd0, 3'd0, 1'b0);

        cyc(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
